// File: rtl/inst_mem_bridge.sv
// inst_mem_bridge: fetch-side request/grant/response bridge
// with timeout, stale-response drop and NOP fault substitution.
module inst_mem_bridge #(
    parameter int          XLEN           = 32,
    parameter int          TIMEOUT_CYCLES = 64,
    parameter logic [31:0] NOP_WORD       = 32'h00000013
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            inst_mem_read_en,
    input  logic [XLEN-1:0] inst_addr,
    output logic [XLEN-1:0] inst_data,
    output logic            inst_mem_ready,
    output logic            fetch_fault,
    output logic [1:0]      fault_cause,
    output logic            bus_req,
    output logic [XLEN-1:0] bus_addr,
    input  logic            bus_gnt,
    input  logic            bus_rvalid,
    input  logic [XLEN-1:0] bus_rdata,
    input  logic            bus_err
);

    typedef enum logic [1:0] {
        IDLE,
        ADDR,
        DATA,
        VALID
    } state_t;

    localparam logic [1:0] C_NONE  = 2'd0;
    localparam logic [1:0] C_ALIGN = 2'd1;
    localparam logic [1:0] C_BUS   = 2'd2;
    localparam logic [1:0] C_TMO   = 2'd3;

    localparam logic [7:0]      TO_LAST = 8'(TIMEOUT_CYCLES - 1);
    localparam logic [XLEN-1:0] NOP     = XLEN'(NOP_WORD);

    state_t          state_q, state_d;
    logic [XLEN-1:0] data_q, data_d;
    logic [XLEN-1:0] addr_q, addr_d;
    logic [1:0]      cause_q, cause_d;
    logic [7:0]      cnt_q, cnt_d;
    logic            stale_q, stale_d;
    logic            expired;

    assign bus_req        = (state_q == ADDR) && !stale_q;
    assign bus_addr       = addr_q;
    assign inst_data      = data_q;
    assign inst_mem_ready = (state_q == VALID);
    assign fault_cause    = cause_q;
    assign fetch_fault    = (cause_q != C_NONE);

    // A grant on the expiry edge pushes the counter past the limit,
    // so compare with >= to still abort on the following DATA cycle.
    assign expired = (cnt_q >= TO_LAST);

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    // Datapath registers: fetched word, bus address, cause, timer, stale.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data_q  <= NOP;
            addr_q  <= '0;
            cause_q <= C_NONE;
            cnt_q   <= '0;
            stale_q <= 1'b0;
        end else begin
            data_q  <= data_d;
            addr_q  <= addr_d;
            cause_q <= cause_d;
            cnt_q   <= cnt_d;
            stale_q <= stale_d;
        end
    end

    // Next-state and datapath update.
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        addr_d  = addr_q;
        cause_d = cause_q;
        cnt_d   = cnt_q;
        stale_d = stale_q;

        // The one outstanding late response is dropped in any state.
        if (stale_q && bus_rvalid) stale_d = 1'b0;

        unique case (state_q)
            IDLE, VALID: begin
                if (inst_mem_read_en) begin
                    cnt_d   = '0;
                    cause_d = C_NONE;
                    if (inst_addr[1:0] != 2'b00) begin
                        state_d = VALID;
                        data_d  = NOP;
                        cause_d = C_ALIGN;
                    end else begin
                        state_d = ADDR;
                        addr_d  = {inst_addr[XLEN-1:2], 2'b00};
                    end
                end
            end
            ADDR: begin
                cnt_d = cnt_q + 8'd1;
                if (bus_req && bus_gnt) begin
                    state_d = DATA;
                end else if (expired) begin
                    state_d = VALID;
                    data_d  = NOP;
                    cause_d = C_TMO;
                end
            end
            DATA: begin
                cnt_d = cnt_q + 8'd1;
                if (bus_rvalid) begin
                    state_d = VALID;
                    if (bus_err) begin
                        data_d  = NOP;
                        cause_d = C_BUS;
                    end else begin
                        data_d  = bus_rdata;
                        cause_d = C_NONE;
                    end
                end else if (expired) begin
                    state_d = VALID;
                    data_d  = NOP;
                    cause_d = C_TMO;
                    stale_d = 1'b1;
                end
            end
        endcase
    end

endmodule

// File: tb/tb_inst_mem_bridge.sv
// tb_inst_mem_bridge: directed bench for inst_mem_bridge
// with TIMEOUT_CYCLES=4 and hand-computed expectations.
module tb_inst_mem_bridge;

    logic        clk = 1'b0;
    logic        rst;
    logic        inst_mem_read_en;
    logic [31:0] inst_addr;
    logic [31:0] inst_data;
    logic        inst_mem_ready;
    logic        fetch_fault;
    logic [1:0]  fault_cause;
    logic        bus_req;
    logic [31:0] bus_addr;
    logic        bus_gnt;
    logic        bus_rvalid;
    logic [31:0] bus_rdata;
    logic        bus_err;

    int checks = 0;
    int errors = 0;
    int hs_cnt = 0;
    int hs0;

    inst_mem_bridge #(
        .XLEN(32),
        .TIMEOUT_CYCLES(4),
        .NOP_WORD(32'h00000013)
    ) dut (
        .clk(clk),
        .rst(rst),
        .inst_mem_read_en(inst_mem_read_en),
        .inst_addr(inst_addr),
        .inst_data(inst_data),
        .inst_mem_ready(inst_mem_ready),
        .fetch_fault(fetch_fault),
        .fault_cause(fault_cause),
        .bus_req(bus_req),
        .bus_addr(bus_addr),
        .bus_gnt(bus_gnt),
        .bus_rvalid(bus_rvalid),
        .bus_rdata(bus_rdata),
        .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    // Count request/grant handshakes seen on the bus.
    always @(posedge clk)
        if (rst && bus_req && bus_gnt) hs_cnt++;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
            $error("%s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0;
        inst_mem_read_en = 1'b0;
        inst_addr = '0;
        bus_gnt = 1'b0;
        bus_rvalid = 1'b0;
        bus_rdata = '0;
        bus_err = 1'b0;
        tick();
        tick();
        check("rst_ready", 32'(inst_mem_ready), 32'd0);
        check("rst_data", inst_data, 32'h13);
        check("rst_req", 32'(bus_req), 32'd0);
        check("rst_fault", 32'(fetch_fault), 32'd0);
        check("rst_cause", 32'(fault_cause), 32'd0);
        check("rst_baddr", bus_addr, 32'd0);
        rst = 1'b1;
        tick();

        // basic fetch, minimum latency
        inst_mem_read_en = 1'b1;
        inst_addr = 32'h0000_0000;
        tick();
        check("t1_ready_T0", 32'(inst_mem_ready), 32'd0);
        check("t1_req_T0", 32'(bus_req), 32'd1);
        check("t1_baddr", bus_addr, 32'h0);
        inst_mem_read_en = 1'b0;
        bus_gnt = 1'b1;
        tick();
        check("t1_req_T1", 32'(bus_req), 32'd0);
        check("t1_ready_T1", 32'(inst_mem_ready), 32'd0);
        bus_gnt = 1'b0;
        bus_rvalid = 1'b1;
        bus_rdata = 32'h0000_0297;
        tick();
        bus_rvalid = 1'b0;
        check("t1_ready", 32'(inst_mem_ready), 32'd1);
        check("t1_data", inst_data, 32'h0000_0297);
        check("t1_cause", 32'(fault_cause), 32'd0);
        check("t1_fault", 32'(fetch_fault), 32'd0);

        // held request, grant on the expiry edge, response on last cycle
        hs0 = hs_cnt;
        inst_mem_read_en = 1'b1;
        inst_addr = 32'h0000_0040;
        tick();
        check("t2_req_T0", 32'(bus_req), 32'd1);
        check("t2_baddr_T0", bus_addr, 32'h40);
        inst_addr = 32'h0000_0080;
        tick();
        tick();
        tick();
        check("t2_req_T3", 32'(bus_req), 32'd1);
        check("t2_baddr_T3", bus_addr, 32'h40);
        check("t2_ready_T3", 32'(inst_mem_ready), 32'd0);
        bus_gnt = 1'b1;
        tick();
        check("t2_req_T4", 32'(bus_req), 32'd0);
        check("t2_ready_T4", 32'(inst_mem_ready), 32'd0);
        bus_gnt = 1'b0;
        bus_rvalid = 1'b1;
        bus_rdata = 32'h1234_5678;
        tick();
        bus_rvalid = 1'b0;
        inst_mem_read_en = 1'b0;
        check("t2_ready", 32'(inst_mem_ready), 32'd1);
        check("t2_data", inst_data, 32'h1234_5678);
        check("t2_cause", 32'(fault_cause), 32'd0);
        check("t2_handshakes", 32'(hs_cnt - hs0), 32'd1);
        check("t2_baddr_end", bus_addr, 32'h40);
        tick();
        check("t2_hold_ready", 32'(inst_mem_ready), 32'd1);
        check("t2_hold_data", inst_data, 32'h1234_5678);

        // misaligned
        inst_mem_read_en = 1'b1;
        inst_addr = 32'h0000_0102;
        tick();
        inst_mem_read_en = 1'b0;
        check("t3_ready", 32'(inst_mem_ready), 32'd1);
        check("t3_req", 32'(bus_req), 32'd0);
        check("t3_data", inst_data, 32'h13);
        check("t3_cause", 32'(fault_cause), 32'd1);
        check("t3_fault", 32'(fetch_fault), 32'd1);
        check("t3_baddr", bus_addr, 32'h40);

        // bus error
        inst_mem_read_en = 1'b1;
        inst_addr = 32'h0000_0200;
        tick();
        check("t4_cause_T0", 32'(fault_cause), 32'd0);
        check("t4_fault_T0", 32'(fetch_fault), 32'd0);
        inst_mem_read_en = 1'b0;
        bus_gnt = 1'b1;
        tick();
        bus_gnt = 1'b0;
        bus_rvalid = 1'b1;
        bus_err = 1'b1;
        bus_rdata = 32'hCAFE_BABE;
        tick();
        bus_rvalid = 1'b0;
        bus_err = 1'b0;
        check("t4_ready", 32'(inst_mem_ready), 32'd1);
        check("t4_data", inst_data, 32'h13);
        check("t4_fault", 32'(fetch_fault), 32'd1);
        check("t4_cause", 32'(fault_cause), 32'd2);

        // timeout in DATA, then stale response dropped
        inst_mem_read_en = 1'b1;
        inst_addr = 32'h0000_0300;
        tick();
        inst_mem_read_en = 1'b0;
        bus_gnt = 1'b1;
        tick();
        bus_gnt = 1'b0;
        tick();
        tick();
        check("t5_ready_T3", 32'(inst_mem_ready), 32'd0);
        tick();
        check("t5_ready", 32'(inst_mem_ready), 32'd1);
        check("t5_cause", 32'(fault_cause), 32'd3);
        check("t5_data", inst_data, 32'h13);
        inst_mem_read_en = 1'b1;
        inst_addr = 32'h0000_0400;
        tick();
        inst_mem_read_en = 1'b0;
        check("t5_stale_req0", 32'(bus_req), 32'd0);
        check("t5_stale_baddr", bus_addr, 32'h400);
        tick();
        check("t5_stale_req1", 32'(bus_req), 32'd0);
        bus_rvalid = 1'b1;
        bus_rdata = 32'hDEAD_BEEF;
        tick();
        bus_rvalid = 1'b0;
        check("t5_drop_ready", 32'(inst_mem_ready), 32'd0);
        check("t5_req_after", 32'(bus_req), 32'd1);
        bus_gnt = 1'b1;
        tick();
        bus_gnt = 1'b0;
        bus_rvalid = 1'b1;
        bus_rdata = 32'hABCD_0001;
        tick();
        bus_rvalid = 1'b0;
        check("t5_next_ready", 32'(inst_mem_ready), 32'd1);
        check("t5_next_data", inst_data, 32'hABCD_0001);
        check("t5_next_cause", 32'(fault_cause), 32'd0);

        // asynchronous reset while in DATA
        inst_mem_read_en = 1'b1;
        inst_addr = 32'h0000_0500;
        tick();
        inst_mem_read_en = 1'b0;
        bus_gnt = 1'b1;
        tick();
        bus_gnt = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        check("t6_ready", 32'(inst_mem_ready), 32'd0);
        check("t6_data", inst_data, 32'h13);
        check("t6_req", 32'(bus_req), 32'd0);
        check("t6_baddr", bus_addr, 32'h0);
        check("t6_cause", 32'(fault_cause), 32'd0);
        tick();
        rst = 1'b1;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
